// File: rtl/c2hdl_mem_arb.sv
// c2hdl_mem_arb: round-robin arbiter that shares one little-endian byte RAM among NCH
// core-bus masters, with programmable wait states and range/size error reporting.
module c2hdl_mem_arb #(
  parameter int          NCH    = 2,
  parameter logic [31:0] BASE   = 32'h1000,
  parameter int          AW_MEM = 12,
  parameter int          WAIT   = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [NCH-1:0]    m_valid,
  input  logic [NCH-1:0]    m_write,
  input  logic [3*NCH-1:0]  m_size,
  input  logic [32*NCH-1:0] m_addr,
  input  logic [32*NCH-1:0] m_wdata,
  output logic [32*NCH-1:0] m_rdata,
  output logic [NCH-1:0]    m_ready,
  output logic [NCH-1:0]    m_err,
  output logic              busy,
  output logic [2:0]        gnt_id,
  output logic [1:0]        dbg_state
);
  // Handshake: a master raises m_valid and holds it until its one-cycle m_ready pulse;
  // m_rdata/m_err are meaningful only while that m_ready is high.
  localparam logic [32:0] MEM_BYTES = 33'd1 << AW_MEM;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAITS = 2'd1, S_RESP = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_rr, r_gnt;
  logic [3:0]  r_cnt;
  logic        r_write, r_err;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_mem [0:(1<<AW_MEM)-1];

  logic        w_any;
  logic [2:0]  w_grant;
  logic        w_src_write;
  logic [2:0]  w_src_size;
  logic [31:0] w_src_addr, w_src_wdata;
  logic [31:0] w_off;
  logic [32:0] w_end;
  logic        w_bad, w_do;
  logic [AW_MEM-1:0] w_o0, w_o1, w_o2, w_o3;
  logic [31:0] w_rword;

  // First requester at or after the rr pointer, scanning modulo NCH.
  always_comb begin
    w_any   = 1'b0;
    w_grant = 3'd0;
    for (int k = 0; k < NCH; k++) begin
      for (int j = 0; j < NCH; j++) begin
        if (!w_any && m_valid[j] && (j == ((int'(r_rr) + k) % NCH))) begin
          w_any   = 1'b1;
          w_grant = 3'(j);
        end
      end
    end
  end

  // With WAIT=0 the access happens on the grant edge, so use the live request then.
  always_comb begin
    w_src_write = r_write;
    w_src_size  = r_size;
    w_src_addr  = r_addr;
    w_src_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      for (int j = 0; j < NCH; j++) begin
        if (w_grant == 3'(j)) begin
          w_src_write = m_write[j];
          w_src_size  = m_size[3*j +: 3];
          w_src_addr  = m_addr[32*j +: 32];
          w_src_wdata = m_wdata[32*j +: 32];
        end
      end
    end
  end

  always_comb begin
    w_off = w_src_addr - BASE;
    case (w_src_size)
      3'd0:    w_end = {1'b0, w_off} + 33'd1;
      3'd1:    w_end = {1'b0, w_off} + 33'd2;
      default: w_end = {1'b0, w_off} + 33'd4;
    endcase
    w_bad   = (w_src_size > 3'd2) || (w_src_addr < BASE) || (w_end > MEM_BYTES);
    w_o0    = w_off[AW_MEM-1:0];
    w_o1    = w_o0 + AW_MEM'(1);
    w_o2    = w_o0 + AW_MEM'(2);
    w_o3    = w_o0 + AW_MEM'(3);
    w_rword = {r_mem[{w_o0[AW_MEM-1:2], 2'b11}], r_mem[{w_o0[AW_MEM-1:2], 2'b10}],
               r_mem[{w_o0[AW_MEM-1:2], 2'b01}], r_mem[{w_o0[AW_MEM-1:2], 2'b00}]};
    w_do    = ((r_state == S_IDLE) && w_any && (WAIT == 0)) ||
              ((r_state == S_WAITS) && (r_cnt == 4'd0));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = (WAIT == 0) ? S_RESP : S_WAITS;
      S_WAITS: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_rr    <= 3'd0;
      r_gnt   <= 3'd0;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_any) begin
        r_gnt   <= w_grant;
        r_rr    <= (w_grant == 3'(NCH-1)) ? 3'd0 : w_grant + 3'd1;
        r_write <= w_src_write;
        r_size  <= w_src_size;
        r_addr  <= w_src_addr;
        r_wdata <= w_src_wdata;
        if (WAIT > 0) r_cnt <= 4'(WAIT - 1);
      end
      if ((r_state == S_WAITS) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
      if (w_do) begin
        r_rdata <= w_bad ? 32'd0 : w_rword;
        r_err   <= w_bad;
      end
    end
  end

  // RAM is never cleared; a reset edge suppresses any write due on that edge.
  always_ff @(posedge clk) begin
    if (rstb && w_do && w_src_write && !w_bad) begin
      r_mem[w_o0] <= w_src_wdata[7:0];
      if (w_src_size != 3'd0) r_mem[w_o1] <= w_src_wdata[15:8];
      if (w_src_size == 3'd2) begin
        r_mem[w_o2] <= w_src_wdata[23:16];
        r_mem[w_o3] <= w_src_wdata[31:24];
      end
    end
  end

  always_comb begin
    m_ready = '0;
    m_err   = '0;
    m_rdata = '0;
    for (int j = 0; j < NCH; j++) begin
      if ((r_state == S_RESP) && (r_gnt == 3'(j))) begin
        m_ready[j]          = 1'b1;
        m_err[j]            = r_err;
        m_rdata[32*j +: 32] = r_rdata;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign gnt_id    = r_gnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_c2hdl_mem_arb.sv
// Bench for c2hdl_mem_arb: one instance with WAIT=0 (dut0) and one with WAIT=3 (dut1),
// directed vectors pushed to per-instance expected queues and checked by a monitor.
module tb_c2hdl_mem_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic [1:0]  a_valid, a_write, b_valid, b_write;
  logic [5:0]  a_size, b_size;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata, a_rdata, b_rdata;
  logic [1:0]  a_ready, a_err, b_ready, b_err;
  logic        a_busy, b_busy;
  logic [2:0]  a_gnt, b_gnt;
  logic [1:0]  a_dbg, b_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  // entry: {skip_rdata, ch[2:0], err, rdata[31:0]}
  logic [36:0] exp_q0[$], exp_q1[$];
  int          lat_q0[$], lat_q1[$];

  c2hdl_mem_arb #(.NCH(2), .BASE(32'h1000), .AW_MEM(12), .WAIT(0)) u_dut0 (
    .clk(clk), .rstb(rstb), .m_valid(a_valid), .m_write(a_write), .m_size(a_size),
    .m_addr(a_addr), .m_wdata(a_wdata), .m_rdata(a_rdata), .m_ready(a_ready),
    .m_err(a_err), .busy(a_busy), .gnt_id(a_gnt), .dbg_state(a_dbg));

  c2hdl_mem_arb #(.NCH(2), .BASE(32'h1000), .AW_MEM(12), .WAIT(3)) u_dut1 (
    .clk(clk), .rstb(rstb), .m_valid(b_valid), .m_write(b_write), .m_size(b_size),
    .m_addr(b_addr), .m_wdata(b_wdata), .m_rdata(b_rdata), .m_ready(b_ready),
    .m_err(b_err), .busy(b_busy), .gnt_id(b_gnt), .dbg_state(b_dbg));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int d, input bit skip, input int ch, input bit err,
                          input logic [31:0] rdata, input int lat);
    if (d == 0) begin
      exp_q0.push_back({skip, 3'(ch), err, rdata});
      lat_q0.push_back(lat);
    end else begin
      exp_q1.push_back({skip, 3'(ch), err, rdata});
      lat_q1.push_back(lat);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle.
  task automatic req(input int d, input int ch, input bit wr, input logic [2:0] sz,
                     input logic [31:0] addr, input logic [31:0] wdata, input bit push,
                     input bit err, input logic [31:0] rdata, input bit skip);
    bit got;
    if (push) push_exp(d, skip, ch, err, rdata, cyc + 1 + ((d == 0) ? 0 : 3));
    if (d == 0) begin
      a_write[ch] = wr; a_size[3*ch +: 3] = sz;
      a_addr[32*ch +: 32] = addr; a_wdata[32*ch +: 32] = wdata; a_valid[ch] = 1'b1;
    end else begin
      b_write[ch] = wr; b_size[3*ch +: 3] = sz;
      b_addr[32*ch +: 32] = addr; b_wdata[32*ch +: 32] = wdata; b_valid[ch] = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      got = (d == 0) ? a_ready[ch] : b_ready[ch];
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout dut%0d ch%0d: ready never seen, required a ready pulse", d, ch);
    end
    if (d == 0) a_valid[ch] = 1'b0;
    else        b_valid[ch] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic mon(input int d, input logic [1:0] rdy, input logic [1:0] er,
                     input logic [63:0] rd, input logic [2:0] gnt);
    logic [36:0] e;
    logic [2:0]  ch;
    int          lat;
    bit          empty;
    for (int k = 0; k < 2; k++) begin
      if (rdy[k] !== 1'b1) begin
        checks++;
        if (er[k] !== 1'b0 || rd[32*k +: 32] !== 32'd0) begin
          errors++;
          $display("FAIL idle_lane dut%0d ch%0d: err=%b rdata=%h, required err=0 rdata=0",
                   d, k, er[k], rd[32*k +: 32]);
        end
      end
    end
    if (rdy !== 2'b00) begin
      empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      checks++;
      if (empty) begin
        errors++;
        $display("FAIL unexpected_ready dut%0d: ready=%b, required no ready", d, rdy);
      end else begin
        if (d == 0) begin e = exp_q0.pop_front(); lat = lat_q0.pop_front(); end
        else        begin e = exp_q1.pop_front(); lat = lat_q1.pop_front(); end
        ch = e[35:33];
        checks++;
        if (rdy !== (2'b01 << ch)) begin
          errors++;
          $display("FAIL ready_chan dut%0d: ready=%b, required ch%0d only", d, rdy, ch);
        end
        checks++;
        if (er[ch] !== e[32]) begin
          errors++;
          $display("FAIL err dut%0d ch%0d: got %b, required %b", d, ch, er[ch], e[32]);
        end
        if (!e[36]) begin
          checks++;
          if (rd[32*ch +: 32] !== e[31:0]) begin
            errors++;
            $display("FAIL rdata dut%0d ch%0d: got %h, required %h", d, ch, rd[32*ch +: 32], e[31:0]);
          end
        end
        checks++;
        if (gnt !== ch) begin
          errors++;
          $display("FAIL gnt_id dut%0d: got %0d, required %0d", d, gnt, ch);
        end
        if (lat >= 0) begin
          checks++;
          if (cyc != lat) begin
            errors++;
            $display("FAIL latency dut%0d ch%0d: ready at cycle %0d, required %0d", d, ch, cyc, lat);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, a_ready, a_err, a_rdata, a_gnt);
      mon(1, b_ready, b_err, b_rdata, b_gnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  initial begin
    int bc;
    rstb = 1'b0;
    a_valid = '0; a_write = '0; a_size = '0; a_addr = '0; a_wdata = '0;
    b_valid = '0; b_write = '0; b_size = '0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // basic word/byte/half traffic with WAIT=0
    req(0, 0, 1'b1, 3'd2, 32'h1004, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b1);
    req(0, 0, 1'b0, 3'd0, 32'h1006, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    req(0, 0, 1'b1, 3'd1, 32'h1005, 32'h1234, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    req(0, 0, 1'b0, 3'd2, 32'h1004, 32'h0, 1'b1, 1'b0, 32'hDE1234EF, 1'b0);
    req(0, 1, 1'b1, 3'd2, 32'h1008, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 1'b1);

    // reset held two edges with a write request pending on both instances
    rstb = 1'b0;
    a_valid = 2'b11; a_write = 2'b01; a_size = 6'o22;
    a_addr = {32'h1008, 32'h1004}; a_wdata = {32'h66666666, 32'h55555555};
    b_valid = 2'b01; b_write = 2'b01; b_size = 6'o02; b_addr = {32'h0, 32'h1100};
    b_wdata = {32'h0, 32'h55555555};
    repeat (2) @(negedge clk);
    chk("reset_ready0", {30'd0, a_ready}, 32'd0);
    chk("reset_busy0", {31'd0, a_busy}, 32'd0);
    chk("reset_gnt0", {29'd0, a_gnt}, 32'd0);
    chk("reset_ready1", {30'd0, b_ready}, 32'd0);
    chk("reset_busy1", {31'd0, b_busy}, 32'd0);
    a_valid = '0; a_write = '0; b_valid = '0; b_write = '0;
    rstb = 1'b1;
    @(negedge clk);

    // both channels contending: grants alternate 0,1,0,1,... and RAM survived reset
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 1'b0, 0, 1'b0, 32'hDE1234EF, -1);
      push_exp(0, 1'b0, 1, 1'b0, 32'h0BADF00D, -1);
    end
    fork
      begin
        for (int i = 0; i < 4; i++)
          req(0, 0, 1'b0, 3'd2, 32'h1004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++)
          req(0, 1, 1'b0, 3'd0, 32'h1008, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      end
    join

    // range and size errors, then legal accesses at the top of the RAM
    req(0, 0, 1'b1, 3'd2, 32'h1FFC, 32'h77665544, 1'b1, 1'b0, 32'h0, 1'b1);
    req(0, 0, 1'b1, 3'd2, 32'h1FFE, 32'hCAFEBABE, 1'b1, 1'b1, 32'h0, 1'b0);
    req(0, 0, 1'b0, 3'd2, 32'h0FFC, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    req(0, 1, 1'b0, 3'd3, 32'h1000, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0);
    req(0, 0, 1'b0, 3'd2, 32'h1FFC, 32'h0, 1'b1, 1'b0, 32'h77665544, 1'b0);
    req(0, 1, 1'b1, 3'd1, 32'h1FFE, 32'hAABB, 1'b1, 1'b0, 32'h77665544, 1'b0);
    req(0, 1, 1'b0, 3'd0, 32'h1FFF, 32'h0, 1'b1, 1'b0, 32'hAABB5544, 1'b0);

    // WAIT=3: ready four cycles after valid, busy for four cycles
    req(1, 0, 1'b1, 3'd2, 32'h1100, 32'hA5A50001, 1'b1, 1'b0, 32'h0, 1'b1);
    bc = 0;
    fork
      req(1, 1, 1'b0, 3'd2, 32'h1100, 32'h0, 1'b1, 1'b0, 32'hA5A50001, 1'b0);
      begin
        repeat (8) begin
          @(negedge clk);
          if (b_busy) bc++;
        end
      end
    join
    chk("busy_cycles", 32'(bc), 32'd4);

    // reset while a write sits in WAITS: write dropped, no ready, rr back to 0
    b_write[0] = 1'b1; b_size[2:0] = 3'd2; b_addr[31:0] = 32'h1100;
    b_wdata[31:0] = 32'h11223344; b_valid[0] = 1'b1;
    @(negedge clk);
    chk("waits_busy", {31'd0, b_busy}, 32'd1);
    rstb = 1'b0;
    b_valid = '0;
    @(negedge clk);
    rstb = 1'b1;
    chk("abort_busy", {31'd0, b_busy}, 32'd0);
    chk("abort_gnt", {29'd0, b_gnt}, 32'd0);
    repeat (6) @(negedge clk);
    push_exp(1, 1'b0, 0, 1'b0, 32'hA5A50001, -1);
    push_exp(1, 1'b0, 1, 1'b0, 32'hA5A50001, -1);
    fork
      req(1, 0, 1'b0, 3'd2, 32'h1100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      req(1, 1, 1'b0, 3'd2, 32'h1100, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    join

    repeat (2) @(negedge clk);
    chk("pending0", 32'(exp_q0.size()), 32'd0);
    chk("pending1", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
